// File: rtl/vga_axil_master_fsm.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : vga_axil_master_fsm
// Purpose  : AXI4-Lite initiator. Turns native single-word write and read
//            requests into AXI-Lite channel transactions. The write and read
//            paths are independent FSMs and may run concurrently.
// Ports    : clk_i / arst_i          - clock, asynchronous active-high reset
//            wr_*                    - native write request / completion
//            rd_*                    - native read request / completion
//            aw*, w*, b*, ar*, r*    - AXI-Lite master channels
// Revision : 1.0 - initial release
// ============================================================================
module vga_axil_master_fsm #(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    // Native write port
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [AXIL_ADDR_WIDTH-1:0]     wr_addr_i,
    input  logic [AXIL_DATA_WIDTH-1:0]     wr_data_i,
    input  logic [AXIL_DATA_WIDTH/8-1:0]   wr_strb_i,
    output logic                           wr_done_o,
    output logic [1:0]                     wr_resp_o,
    // Native read port
    input  logic                           rd_valid_i,
    output logic                           rd_ready_o,
    input  logic [AXIL_ADDR_WIDTH-1:0]     rd_addr_i,
    output logic                           rd_done_o,
    output logic [AXIL_DATA_WIDTH-1:0]     rd_data_o,
    output logic [1:0]                     rd_resp_o,
    // AXI-Lite write address / data / response
    output logic [AXIL_ADDR_WIDTH-1:0]     awaddr,
    output logic [2:0]                     awprot,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [AXIL_DATA_WIDTH-1:0]     wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0]   wstrb,
    output logic                           wvalid,
    input  logic                           wready,
    input  logic [1:0]                     bresp,
    input  logic                           bvalid,
    output logic                           bready,
    // AXI-Lite read address / data
    output logic [AXIL_ADDR_WIDTH-1:0]     araddr,
    output logic [2:0]                     arprot,
    output logic                           arvalid,
    input  logic                           arready,
    input  logic [AXIL_DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rvalid,
    output logic                           rready
);

    localparam int c_STRB_WIDTH = AXIL_DATA_WIDTH / 8;
    // Clears the byte-offset bits so every bus address is word aligned.
    localparam logic [AXIL_ADDR_WIDTH-1:0] c_ALIGN_MASK =
        ~AXIL_ADDR_WIDTH'(c_STRB_WIDTH - 1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP, W_DONE} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_t                     wr_state_q, wr_state_d;
    logic                          wr_ready_q, wr_ready_d;
    logic [AXIL_ADDR_WIDTH-1:0]    awaddr_q,   awaddr_d;
    logic                          awvalid_q,  awvalid_d;
    logic [AXIL_DATA_WIDTH-1:0]    wdata_q,    wdata_d;
    logic [c_STRB_WIDTH-1:0]       wstrb_q,    wstrb_d;
    logic                          wvalid_q,   wvalid_d;
    logic                          bready_q,   bready_d;
    logic                          wr_done_q,  wr_done_d;
    logic [1:0]                    wr_resp_q,  wr_resp_d;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_t                     rd_state_q, rd_state_d;
    logic                          rd_ready_q, rd_ready_d;
    logic [AXIL_ADDR_WIDTH-1:0]    araddr_q,   araddr_d;
    logic                          arvalid_q,  arvalid_d;
    logic                          rready_q,   rready_d;
    logic                          rd_done_q,  rd_done_d;
    logic [AXIL_DATA_WIDTH-1:0]    rd_data_q,  rd_data_d;
    logic [1:0]                    rd_resp_q,  rd_resp_d;

    // Write FSM next state. Every output is computed one cycle ahead so
    // no valid ever depends combinationally on a ready.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ready_d = wr_ready_q;
        awaddr_d   = awaddr_q;
        awvalid_d  = awvalid_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        wr_done_d  = 1'b0;
        wr_resp_d  = wr_resp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_valid_i && wr_ready_q) begin
                    awaddr_d   = wr_addr_i & c_ALIGN_MASK;
                    wdata_d    = wr_data_i;
                    wstrb_d    = wr_strb_i;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    wr_ready_d = 1'b0;
                    wr_state_d = W_ADDR_DATA;
                end
            end
            W_ADDR_DATA: begin
                // AW and W retire independently; each valid drops on its own
                // handshake and stays low for the rest of the transaction.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d   = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    wr_resp_d  = bresp;
                    bready_d   = 1'b0;
                    wr_done_d  = 1'b1;
                    wr_state_d = W_DONE;
                end
            end
            W_DONE: begin
                wr_ready_d = 1'b1;
                wr_state_d = W_IDLE;
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // Read FSM next state.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ready_d = rd_ready_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rd_done_d  = 1'b0;
        rd_data_d  = rd_data_q;
        rd_resp_d  = rd_resp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_valid_i && rd_ready_q) begin
                    araddr_d   = rd_addr_i & c_ALIGN_MASK;
                    arvalid_d  = 1'b1;
                    rd_ready_d = 1'b0;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid) begin
                    rd_data_d  = rdata;
                    rd_resp_d  = rresp;
                    rready_d   = 1'b0;
                    rd_done_d  = 1'b1;
                    rd_state_d = R_DONE;
                end
            end
            R_DONE: begin
                rd_ready_d = 1'b1;
                rd_state_d = R_IDLE;
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // Reset abandons any transaction in flight: valids/readies on the AXI
    // side drop at once and no done pulse is produced.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_state_q <= W_IDLE;
            wr_ready_q <= 1'b1;
            awaddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= 2'b00;
            rd_state_q <= R_IDLE;
            rd_ready_q <= 1'b1;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_resp_q  <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            wr_ready_q <= wr_ready_d;
            awaddr_q   <= awaddr_d;
            awvalid_q  <= awvalid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            wr_done_q  <= wr_done_d;
            wr_resp_q  <= wr_resp_d;
            rd_state_q <= rd_state_d;
            rd_ready_q <= rd_ready_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= rd_data_d;
            rd_resp_q  <= rd_resp_d;
        end
    end

    assign wr_ready_o = wr_ready_q;
    assign wr_done_o  = wr_done_q;
    assign wr_resp_o  = wr_resp_q;
    assign awaddr     = awaddr_q;
    assign awprot     = 3'b000;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;

    assign rd_ready_o = rd_ready_q;
    assign rd_done_o  = rd_done_q;
    assign rd_data_o  = rd_data_q;
    assign rd_resp_o  = rd_resp_q;
    assign araddr     = araddr_q;
    assign arprot     = 3'b000;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;

endmodule
`default_nettype wire
